auction_bid_collector: RTL and testbench
========================================

# auction_bid_collector

Upstream feeder for the combinational `auction` block. It gathers sealed bids that arrive serially, one bidder per transfer, over a valid/ready handshake. Once every bidder has bid, or the round is force-closed, it presents the packed `(2**N)*W`-bit `bid` vector and holds it stable until the consumer acknowledges. It then clears itself for the next round.

## Interface
- `N`, default 3: bidder index width; `2**N` bidders.
- `W`, default 3: bid width in bits.

- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: a bid is offered this cycle.
- `in_ready` output, 1: collector can accept a bid.
- `in_id` input, N: bidder index of the offered bid.
- `in_bid` input, W: offered bid value, unsigned.
- `close` input, 1: force the round to end (auction timeout).
- `bid` output, `(2**N)*W`: packed bids; bidder i occupies `[(i+1)*W-1:i*W]`. Connects directly to `auction.bid`.
- `submitted` output, `2**N`: bit i is set once bidder i's bid has been stored this round.
- `out_valid` output, 1: `bid` is complete and stable.
- `out_ready` input, 1: consumer has sampled `bid`/`winner`.
- `dup_err` output, 1: one-cycle pulse when a bid is rejected as a duplicate.

## Operation
- There are two states, COLLECT and HOLD. Reset enters COLLECT.
- Reset values: `bid`=0, `submitted`=0, `out_valid`=0, `dup_err`=0, state=COLLECT, so `in_ready`=1.
- `in_ready` = (state==COLLECT). It is decoded from the registered state and does not depend on `in_valid`.
- Accept: `in_valid & in_ready`. On accept, the lane `in_id` is written with `in_bid` and `submitted[in_id]` is set.
- Duplicate, meaning accept while `submitted[in_id]` is already 1: behaviour depends on configuration. The handshake still completes; the bid is consumed, not stalled.
- COLLECT → HOLD at the edge where either condition holds:
  - the accept in that cycle makes `submitted` all-ones, or
  - `close` is high.
- If an accept and `close` occur in the same cycle, the bid is stored first and then the round closes.
- `close` in HOLD is ignored.
- Bidders that never submitted keep lane value 0. Tie resolution is the downstream block's rule.
- HOLD: `out_valid`=1. `bid` and `submitted` are frozen.
- HOLD → COLLECT on `out_ready`. In that same edge, `bid` and `submitted` clear to 0 and `out_valid` drops.
- `out_ready` in COLLECT is ignored.
- `rst` in either state, including mid-round, immediately discards all stored bids and restores the reset values.
- All arithmetic is lane storage only; there is no widening or saturation. `in_id` is always in range because `2**N` lanes exist.

## Timing
- Accept-to-storage: `bid` lane and `submitted` bit update at the accepting edge, visible the next cycle.
- Closing accept (or `close`) at edge k: `out_valid`=1 and `in_ready`=0 from cycle k+1.
- The minimum round with `2**N` bidders back-to-back is `2**N` accept cycles plus 1 HOLD cycle when `out_ready` is tied high.
- `out_ready` at edge m in HOLD: `in_ready`=1 at m+1. A new accept is possible at edge m+1 with no bubble beyond that.
- `dup_err` is registered: it is high exactly one cycle after the offending accept.

## Configuration
- `AUCTION_REBID_EN` defined: a duplicate overwrites the stored lane (last bid wins) and `dup_err` stays 0.
- `AUCTION_REBID_EN` undefined (default): a duplicate is discarded, the first bid is kept, and `dup_err` pulses.

## Test plan
- Reset, then bids id0..7 = 6,0,1,4,3,7,5,2 on consecutive cycles, `out_ready`=0 → `out_valid` rises the cycle after id7; `bid`=0x57B846, `submitted`=0xFF. Held stable for 10 cycles with `in_ready`=0.
- From that HOLD state, pulse `out_ready` → next cycle `bid`=0, `submitted`=0, `out_valid`=0, `in_ready`=1.
- Bids only id2=5 and id6=7, then `close` → `out_valid` next cycle; `bid`=0x1C0140 (lanes 2 and 6 set, others 0); `submitted`=0x44.
- Default build: id3=4, then id3=1 → lane3 stays 4 and `dup_err` is high for one cycle. With `AUCTION_REBID_EN`: lane3=1 and `dup_err`=0.
- Seven bids, then an eighth accept with `close` asserted in the same cycle → the eighth bid is stored and `submitted`=0xFF. Exactly one HOLD entry occurs.
- Assert `rst` for one cycle after four bids → all outputs return to reset values. A following full round behaves as in the first scenario.

Source files
------------

// File: rtl/auction_bid_collector.sv
// auction_bid_collector
//   Gathers sealed bids from 2**N bidders, one per valid/ready transfer, and
//   presents the packed bid vector to the combinational auction block. The
//   vector is held until the consumer acknowledges. The collector then clears
//   itself for the next round.
//
//   Parameters : N (bidder index width, 2**N lanes), W (bid width)
//   Ports      : clk, rst (sync, active high)
//                in_valid/in_ready/in_id/in_bid  - serial bid input handshake
//                close                           - force-close the round
//                bid[(2**N)*W-1:0]               - packed lanes, lane i at [i*W +: W]
//                submitted[2**N-1:0]             - per-bidder "stored this round"
//                out_valid/out_ready             - round-complete handshake
//                dup_err                         - 1-cycle pulse on a rejected duplicate
//
//   Build option: define AUCTION_REBID_EN to let a repeat bid overwrite the
//   stored lane (last bid wins, no dup_err). Without it the first bid is kept
//   and dup_err pulses.

// One bidder's storage: the bid value plus its submitted flag.
module auction_bid_lane #(
  parameter int W     = 3,
  parameter bit REBID = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         sel,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         sub
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      sub <= 1'b0;
    end else if (sel) begin
      // A repeat bid only lands when rebidding is enabled.
      if (!sub || REBID) q <= din;
      sub <= 1'b1;
    end
  end
endmodule

module auction_bid_collector #(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_id,
  input  logic [W-1:0]         in_bid,
  input  logic                 close,
  output logic [(2**N)*W-1:0]  bid,
  output logic [2**N-1:0]      submitted,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 dup_err
);
  localparam int NL = 2**N;

`ifdef AUCTION_REBID_EN
  localparam bit REBID = 1'b1;
`else
  localparam bit REBID = 1'b0;
`endif

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   dup_hit;
  logic                   clr;
  logic [NL-1:0]          sel;
  logic [NL-1:0][W-1:0]   lane_q;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign dup_hit   = accept && submitted[in_id];
  assign bid       = lane_q;

  always_comb begin
    sel = '0;
    if (accept) sel[in_id] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < NL; i++) begin : g_lane
      auction_bid_lane #(.W(W), .REBID(REBID)) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .sel (sel[i]),
        .din (in_bid),
        .q   (lane_q[i]),
        .sub (submitted[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Close on force-close or when this cycle's accept fills the last lane;
  // the accepted bid still lands on the same edge.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      COLLECT: if (close || (accept && (&(submitted | sel)))) state_nxt = HOLD;
      HOLD: if (out_ready) begin
        state_nxt = COLLECT;
        clr       = 1'b1;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) dup_err <= 1'b0;
    else     dup_err <= dup_hit && !REBID;
  end
endmodule

// File: tb/tb_auction_bid_collector.sv
module tb_auction_bid_collector;
  localparam int N  = 3;
  localparam int W  = 3;
  localparam int NL = 8;

`ifdef AUCTION_REBID_EN
  localparam bit REBID = 1'b1;
`else
  localparam bit REBID = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_id;
  logic [W-1:0]    in_bid;
  logic            close;
  logic [NL*W-1:0] bid;
  logic [NL-1:0]   submitted;
  logic            out_valid;
  logic            out_ready;
  logic            dup_err;

  int checks = 0;
  int errors = 0;

  // Reference model: one bid value and one flag per bidder, plus round phase.
  int  mbid [NL];
  bit  msub [NL];
  bit  mhold;
  bit  mdup;
  int  hold_entries;

  auction_bid_collector #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_bid    (in_bid),
    .close     (close),
    .bid       (bid),
    .submitted (submitted),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL*W-1:0] mpack();
    logic [NL*W-1:0] v = '0;
    for (int k = 0; k < NL; k++) v = v | ((NL*W)'(mbid[k]) << (k*W));
    return v;
  endfunction

  function automatic logic [NL-1:0] msubv();
    logic [NL-1:0] v = '0;
    for (int k = 0; k < NL; k++) v[k] = msub[k];
    return v;
  endfunction

  function automatic bit mall();
    for (int k = 0; k < NL; k++) if (!msub[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mclear();
    for (int k = 0; k < NL; k++) begin mbid[k] = 0; msub[k] = 0; end
  endtask

  // Round rules applied at each rising edge from the inputs driven before it.
  task automatic model_edge();
    if (rst) begin
      mclear(); mhold = 0; mdup = 0;
    end else if (!mhold) begin
      mdup = 0;
      if (in_valid) begin
        if (msub[in_id]) begin
          if (REBID) mbid[in_id] = int'(in_bid);
          else       mdup = 1;
        end else begin
          mbid[in_id] = int'(in_bid);
          msub[in_id] = 1;
        end
      end
      if (close || mall()) begin mhold = 1; hold_entries++; end
    end else begin
      mdup = 0;
      if (out_ready) begin mclear(); mhold = 0; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},  64'(in_ready),  64'(!mhold));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mhold));
    chk({tag, ".bid"},       64'(bid),       64'(mpack()));
    chk({tag, ".submitted"}, 64'(submitted), 64'(msubv()));
    chk({tag, ".dup_err"},   64'(dup_err),   64'(mdup));
  endtask

  task automatic cyc(input string tag, input logic v, input int id, input int b,
                     input logic cl, input logic ordy, input logic r);
    in_valid = v; in_id = N'(id); in_bid = W'(b); close = cl; out_ready = ordy; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag, 0, 0, 0, 0, 0, 0);
  endtask

  int s1 [NL] = '{6, 0, 1, 4, 3, 7, 5, 2};

  initial begin
    mclear(); mhold = 0; mdup = 0; hold_entries = 0;
    in_valid = 0; in_id = '0; in_bid = '0; close = 0; out_ready = 0; rst = 1;

    // Reset state
    cyc("reset", 0, 0, 0, 0, 0, 1);
    cyc("reset2", 0, 0, 0, 0, 0, 1);
    chk("reset_bid", 64'(bid), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);

    // Full round back-to-back, consumer not ready
    for (int k = 0; k < NL; k++) begin
      chk("s1_ready_before_last", 64'(out_valid), 64'h0);
      cyc("s1", 1, k, s1[k], 0, 0, 0);
    end
    chk("s1_bid", 64'(bid), 64'h57B846);
    chk("s1_sub", 64'(submitted), 64'hFF);
    chk("s1_out_valid", 64'(out_valid), 64'h1);
    // Held stable; offered bids and close are ignored
    for (int k = 0; k < 10; k++) cyc("s1_hold", k[0], k % NL, 3, k[1], 0, 0);
    chk("s1_hold_bid", 64'(bid), 64'h57B846);
    chk("s1_hold_in_ready", 64'(in_ready), 64'h0);

    // Acknowledge
    cyc("s2_ack", 0, 0, 0, 0, 1, 0);
    chk("s2_bid", 64'(bid), 64'h0);
    chk("s2_sub", 64'(submitted), 64'h0);
    chk("s2_out_valid", 64'(out_valid), 64'h0);
    chk("s2_in_ready", 64'(in_ready), 64'h1);
    cyc("s2_oready_collect", 0, 0, 0, 0, 1, 0);

    // Partial round force-closed
    cyc("s3", 1, 2, 5, 0, 0, 0);
    cyc("s3", 1, 6, 7, 0, 0, 0);
    cyc("s3_close", 0, 0, 0, 1, 0, 0);
    chk("s3_bid", 64'(bid), 64'h1C0140);
    chk("s3_sub", 64'(submitted), 64'h44);
    chk("s3_out_valid", 64'(out_valid), 64'h1);
    cyc("s3_ack", 0, 0, 0, 0, 1, 0);

    // Duplicate bid
    cyc("s4", 1, 3, 4, 0, 0, 0);
    cyc("s4_dup", 1, 3, 1, 0, 0, 0);
    chk("s4_lane3", 64'(bid[3*W +: W]), REBID ? 64'd1 : 64'd4);
    chk("s4_dup_err", 64'(dup_err), REBID ? 64'd0 : 64'd1);
    cyc("s4_after", 0, 0, 0, 0, 0, 0);
    chk("s4_dup_err_drop", 64'(dup_err), 64'd0);
    cyc("s4_close", 0, 0, 0, 1, 0, 0);
    cyc("s4_ack", 0, 0, 0, 0, 1, 0);

    // Eighth accept coincides with close: stored, single hold entry
    hold_entries = 0;
    for (int k = 0; k < NL - 1; k++) cyc("s5", 1, k, k + 1, 0, 0, 0);
    cyc("s5_last", 1, 7, 6, 1, 0, 0);
    chk("s5_sub", 64'(submitted), 64'hFF);
    chk("s5_lane7", 64'(bid[7*W +: W]), 64'd6);
    idle("s5_hold", 3);
    cyc("s5_ack", 0, 0, 0, 0, 1, 0);
    idle("s5_post", 2);
    chk("s5_hold_entries", 64'(hold_entries), 64'd1);
    chk("s5_out_valid_after", 64'(out_valid), 64'd0);

    // Reset mid-round, then a clean full round
    for (int k = 0; k < 4; k++) cyc("s6", 1, k, 7 - k, 0, 0, 0);
    cyc("s6_rst", 0, 0, 0, 0, 0, 1);
    chk("s6_bid", 64'(bid), 64'h0);
    chk("s6_sub", 64'(submitted), 64'h0);
    chk("s6_in_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < NL; k++) cyc("s6_round", 1, k, s1[k], 0, 0, 0);
    chk("s6_round_bid", 64'(bid), 64'h57B846);
    cyc("s6_ack", 0, 0, 0, 0, 1, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      cyc("rnd",
          logic'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, NL - 1)),
          int'($urandom_range(0, 7)),
          logic'($urandom_range(0, 15) == 0),
          logic'($urandom_range(0, 2) == 0),
          logic'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
